// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two
// valid/ready requesters and returns registered results on a tagged response channel.
module alu_arbiter #(
    parameter int WIDTH       = 4,
    parameter int OPW         = 4,
    parameter int EXEC_CYCLES = 1,
    parameter int LAST_OP     = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_y0,
    input  logic [WIDTH-1:0] alu_y1,
    input  logic [1:0]       alu_ov,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y0,
    output logic [WIDTH-1:0] rsp_y1,
    output logic [1:0]       rsp_ov,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]     CNT_LOAD  = 4'(EXEC_CYCLES - 1);
    localparam logic [OPW-1:0] LAST_OP_V = OPW'(LAST_OP);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y0_q, rsp_y0_d;
    logic [WIDTH-1:0] rsp_y1_q, rsp_y1_d;
    logic [1:0]       rsp_ov_q, rsp_ov_d;
    logic             rsp_err_q, rsp_err_d;

    logic             gnt;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [OPW-1:0]   sel_op;

    // Pointer only matters on contention; a lone requester is always granted.
    always_comb begin
        gnt    = (req_valid == 2'b11) ? ptr_q : req_valid[1];
        sel_a  = gnt ? req1_a  : req0_a;
        sel_b  = gnt ? req1_b  : req0_b;
        sel_op = gnt ? req1_op : req0_op;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        rsp_id_d  = rsp_id_q;
        rsp_y0_d  = rsp_y0_q;
        rsp_y1_d  = rsp_y1_q;
        rsp_ov_d  = rsp_ov_q;
        rsp_err_d = rsp_err_q;
        req_ready = 2'b00;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[gnt] = 1'b1;
                    alu_a_d        = sel_a;
                    alu_b_d        = sel_b;
                    alu_op_d       = sel_op;
                    rsp_id_d       = gnt;
                    if (sel_op <= LAST_OP_V) begin
                        cnt_d   = CNT_LOAD;
                        state_d = EXEC;
                    end else begin
                        // Illegal opcode bypasses the ALU and reports an error immediately.
                        rsp_y0_d  = '0;
                        rsp_y1_d  = '0;
                        rsp_ov_d  = '0;
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_y0_d  = alu_y0;
                    rsp_y1_d  = alu_y1;
                    rsp_ov_d  = alu_ov;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = ~rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            cnt_q     <= 4'd0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            rsp_id_q  <= 1'b0;
            rsp_y0_q  <= '0;
            rsp_y1_q  <= '0;
            rsp_ov_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rsp_id_q  <= rsp_id_d;
            rsp_y0_q  <= rsp_y0_d;
            rsp_y1_q  <= rsp_y1_d;
            rsp_ov_q  <= rsp_ov_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_y0    = rsp_y0_q;
    assign rsp_y1    = rsp_y1_q;
    assign rsp_ov    = rsp_ov_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a table of single transactions on an EXEC_CYCLES=1 instance plus
// hand sequences for fairness, backpressure and reset during EXEC on an EXEC_CYCLES=4 instance.
module tb_alu_arbiter;

    logic       clk;
    logic       rst, rst_x4;
    logic [1:0] req_valid, req_valid_x4;
    logic [1:0] req_ready, req_ready_x4;
    logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic       rsp_ready;

    logic [3:0] alu_a, alu_b, alu_op, alu_y0, alu_y1;
    logic [1:0] alu_ov;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [3:0] rsp_y0, rsp_y1;
    logic [1:0] rsp_ov;

    logic [3:0] alu_a_x4, alu_b_x4, alu_op_x4, alu_y0_x4, alu_y1_x4;
    logic [1:0] alu_ov_x4;
    logic       rsp_valid_x4, rsp_id_x4, rsp_err_x4;
    logic [3:0] rsp_y0_x4, rsp_y1_x4;
    logic [1:0] rsp_ov_x4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference ALU: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 MULTU, 13 SLT.
    // ov = {carry/borrow, signed overflow}.
    function automatic logic [9:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] y0, y1;
        logic [1:0] ov;
        y0 = 4'd0; y1 = 4'd0; ov = 2'd0; s = 5'd0; p = 8'd0;
        case (op)
            4'd0: y0 = a & b;
            4'd1: y0 = a | b;
            4'd2: y0 = a ^ b;
            4'd3: y0 = ~(a | b);
            4'd4: begin
                s  = {1'b0, a} + {1'b0, b};
                y0 = s[3:0];
                ov = {s[4], (a[3] == b[3]) && (s[3] != a[3])};
            end
            4'd5: begin
                s  = {1'b0, a} - {1'b0, b};
                y0 = s[3:0];
                ov = {s[4], (a[3] != b[3]) && (s[3] != a[3])};
            end
            4'd6: begin
                p  = {4'd0, a} * {4'd0, b};
                y0 = p[3:0];
                y1 = p[7:4];
            end
            4'd13: y0 = {3'd0, ($signed(a) < $signed(b))};
            default: ;
        endcase
        return {y1, y0, ov};
    endfunction

    assign {alu_y1, alu_y0, alu_ov}          = alu_f(alu_a, alu_b, alu_op);
    assign {alu_y1_x4, alu_y0_x4, alu_ov_x4} = alu_f(alu_a_x4, alu_b_x4, alu_op_x4);

    alu_arbiter #(.WIDTH(4), .OPW(4), .EXEC_CYCLES(1), .LAST_OP(13)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y0(alu_y0), .alu_y1(alu_y1), .alu_ov(alu_ov),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y0(rsp_y0), .rsp_y1(rsp_y1), .rsp_ov(rsp_ov), .rsp_err(rsp_err)
    );

    alu_arbiter #(.WIDTH(4), .OPW(4), .EXEC_CYCLES(4), .LAST_OP(13)) u_dut_x4 (
        .clk(clk), .rst(rst_x4),
        .req_valid(req_valid_x4), .req_ready(req_ready_x4),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a_x4), .alu_b(alu_b_x4), .alu_op(alu_op_x4),
        .alu_y0(alu_y0_x4), .alu_y1(alu_y1_x4), .alu_ov(alu_ov_x4),
        .rsp_valid(rsp_valid_x4), .rsp_ready(rsp_ready), .rsp_id(rsp_id_x4),
        .rsp_y0(rsp_y0_x4), .rsp_y1(rsp_y1_x4), .rsp_ov(rsp_ov_x4), .rsp_err(rsp_err_x4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [3:0] a0, b0, op0, a1, b1, op1;
        logic       id;
        logic [3:0] y0, y1;
        logic [1:0] ov;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vt[9];

    // Entered just after a rising edge; returns just after a rising edge with DUT idle.
    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        bit   got;
        v = vt[i];
        req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
        req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
        req_valid = v.valid;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(2'b01 << v.id));
        @(posedge clk); #1;
        req_valid = 2'b00;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        chk($sformatf("v%0d rsp_valid seen", i), 32'(got), 32'd1);
        chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(v.id));
        chk($sformatf("v%0d rsp_y0", i), 32'(rsp_y0), 32'(v.y0));
        chk($sformatf("v%0d rsp_y1", i), 32'(rsp_y1), 32'(v.y1));
        chk($sformatf("v%0d rsp_ov", i), 32'(rsp_ov), 32'(v.ov));
        chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(v.err));
        chk($sformatf("v%0d alu_a", i), 32'(alu_a), 32'(v.id ? v.a1 : v.a0));
        chk($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(v.id ? v.op1 : v.op0));
        chk($sformatf("v%0d ready in RESP", i), 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d rsp_valid after accept", i), 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int  lat, hs, cyc, last_cyc;
        bit  got, seen, exp_g;

        vt[0] = '{2'b01, 4'b0101, 4'b1000, 4'd0,  4'd0,    4'd0,    4'd0,  1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 2};
        vt[1] = '{2'b10, 4'd0,    4'd0,    4'd0,  4'b0101, 4'b1000, 4'd1,  1'b1, 4'b1101, 4'b0000, 2'b00, 1'b0, 2};
        vt[2] = '{2'b11, 4'b1101, 4'b1000, 4'd4,  4'b0101, 4'b1000, 4'd6,  1'b0, 4'b0101, 4'b0000, 2'b11, 1'b0, 2};
        vt[3] = '{2'b11, 4'b1101, 4'b1000, 4'd4,  4'b0101, 4'b1000, 4'd6,  1'b1, 4'b1000, 4'b0010, 2'b00, 1'b0, 2};
        vt[4] = '{2'b10, 4'd0,    4'd0,    4'd0,  4'b0011, 4'b0110, 4'd15, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1};
        vt[5] = '{2'b01, 4'b0011, 4'b0101, 4'd5,  4'd0,    4'd0,    4'd0,  1'b0, 4'b1110, 4'b0000, 2'b10, 1'b0, 2};
        vt[6] = '{2'b11, 4'b1010, 4'b0110, 4'd2,  4'b0001, 4'b0010, 4'd14, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1};
        vt[7] = '{2'b01, 4'b1000, 4'b0001, 4'd13, 4'd0,    4'd0,    4'd0,  1'b0, 4'b0001, 4'b0000, 2'b00, 1'b0, 2};
        vt[8] = '{2'b10, 4'd0,    4'd0,    4'd0,  4'b0111, 4'b0001, 4'd4,  1'b1, 4'b1000, 4'b0000, 2'b01, 1'b0, 2};

        rst = 1'b1; rst_x4 = 1'b1;
        req_valid = 2'b00; req_valid_x4 = 2'b00; rsp_ready = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_op = 4'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_op = 4'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rst_x4 = 1'b0;

        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_b", 32'(alu_b), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset rsp_y0", 32'(rsp_y0), 32'd0);
        chk("reset rsp_y1", 32'(rsp_y1), 32'd0);
        chk("reset rsp_ov", 32'(rsp_ov), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset x4 rsp_valid", 32'(rsp_valid_x4), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Fairness and throughput: both requesters always valid, response always accepted.
        req0_a = 4'b0110; req0_b = 4'b0011; req0_op = 4'd0;
        req1_a = 4'b0110; req1_b = 4'b0011; req1_op = 4'd1;
        req_valid = 2'b11; rsp_ready = 1'b1;
        hs = 0; cyc = 0; last_cyc = 0; exp_g = 1'b0;
        while (hs < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            chk("fair ready onehot", 32'(req_ready == 2'b11), 32'd0);
            if (|(req_ready & req_valid)) begin
                chk($sformatf("fair grant %0d", hs), 32'(req_ready[1]), 32'(exp_g));
                if (hs > 0) chk($sformatf("fair spacing %0d", hs), 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                exp_g    = ~exp_g;
                hs++;
                if (hs == 8) begin
                    @(posedge clk); #1;
                    req_valid = 2'b00;
                end
            end
        end
        chk("fair handshake count", 32'(hs), 32'd8);
        repeat (5) @(posedge clk);
        #1; rsp_ready = 1'b0;

        // Backpressure: response held for 5 cycles while req1 waits.
        req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 4'd2;
        req1_a = 4'b0001; req1_b = 4'b0100; req1_op = 4'd1;
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp req_ready", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b10;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        chk("bp rsp_valid seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp hold valid %0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp hold y0 %0d", k), 32'(rsp_y0), 32'b0110);
            chk($sformatf("bp hold id %0d", k), 32'(rsp_id), 32'd0);
            chk($sformatf("bp ready low %0d", k), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp idle grants req1", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        chk("bp next rsp seen", 32'(got), 32'd1);
        chk("bp next id", 32'(rsp_id), 32'd1);
        chk("bp next y0", 32'(rsp_y0), 32'b0101);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // EXEC_CYCLES=4 instance: reset in the second EXEC cycle, then a normal transaction.
        req0_a = 4'b0011; req0_b = 4'b0100; req0_op = 4'd4;
        req_valid_x4 = 2'b01;
        @(negedge clk);
        chk("x4 req_ready", 32'(req_ready_x4), 32'b01);
        @(posedge clk); #1;
        req_valid_x4 = 2'b00;
        @(negedge clk);
        chk("x4 alu_a latched", 32'(alu_a_x4), 32'b0011);
        @(posedge clk); #1;
        rst_x4 = 1'b1;
        @(posedge clk); #1;
        rst_x4 = 1'b0;
        @(negedge clk);
        chk("x4 rst rsp_valid", 32'(rsp_valid_x4), 32'd0);
        chk("x4 rst req_ready", 32'(req_ready_x4), 32'd0);
        chk("x4 rst alu_a", 32'(alu_a_x4), 32'd0);
        chk("x4 rst alu_b", 32'(alu_b_x4), 32'd0);
        chk("x4 rst alu_op", 32'(alu_op_x4), 32'd0);
        chk("x4 rst rsp_y0", 32'(rsp_y0_x4), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_x4) seen = 1'b1;
        end
        chk("x4 no response after reset", 32'(seen), 32'd0);
        @(posedge clk); #1;
        req1_a = 4'b0011; req1_b = 4'b0101; req1_op = 4'd6;
        req_valid_x4 = 2'b10;
        @(negedge clk);
        chk("x4 post req_ready", 32'(req_ready_x4), 32'b10);
        @(posedge clk); #1;
        req_valid_x4 = 2'b00;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_x4) got = 1'b1;
        end
        chk("x4 rsp seen", 32'(got), 32'd1);
        chk("x4 latency", 32'(lat), 32'd5);
        chk("x4 rsp_id", 32'(rsp_id_x4), 32'd1);
        chk("x4 rsp_y0", 32'(rsp_y0_x4), 32'b1111);
        chk("x4 rsp_y1", 32'(rsp_y1_x4), 32'b0000);
        chk("x4 rsp_err", 32'(rsp_err_x4), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("x4 accepted", 32'(rsp_valid_x4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
